// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with checked parallel load, terminal wrap pulse and seven-segment outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_updown_counter #(
  parameter int DIGITS    = 2,
  parameter int MAX_VALUE = 99
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadVal,
  output logic [4*DIGITS-1:0]   Count,
  output logic [7*DIGITS-1:0]   Seg,
  output logic                  Wrap,
  output logic                  LoadErr
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    int t;
    t      = v;
    to_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(t % 10);
      t                = t / 10;
    end
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  logic         load_ok;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;

  // With every digit in 0..9, packed BCD order equals decimal order, so a plain compare suffices.
  always_comb begin
    logic digits_ok;
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (LoadVal[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    load_ok = digits_ok && (LoadVal <= MAX_BCD);
  end

  always_comb begin
    logic carry;
    logic borrow;
    inc_val = Count;
    dec_val = Count;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (Count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = Count[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (Count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = Count[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Count   <= '0;
      Wrap    <= 1'b0;
      LoadErr <= 1'b0;
    end else begin
      Wrap    <= 1'b0;
      LoadErr <= 1'b0;
      if (Load) begin
        if (load_ok) begin
          Count <= LoadVal;
        end else begin
          Count   <= '0;
          LoadErr <= 1'b1;
        end
      end else if (En) begin
        if (Up) begin
          if (Count == MAX_BCD) begin
            Count <= '0;
            Wrap  <= 1'b1;
          end else begin
            Count <= inc_val;
          end
        end else begin
          if (Count == '0) begin
            Count <= MAX_BCD;
            Wrap  <= 1'b1;
          end else begin
            Count <= dec_val;
          end
        end
      end
    end
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic hi_zero;
    hi_zero = 1'b1;
`endif
    Seg = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      Seg[7*i +: 7] = seg7(Count[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && hi_zero && Count[4*i +: 4] == 4'd0) Seg[7*i +: 7] = 7'b1111111;
      if (Count[4*i +: 4] != 4'd0) hi_zero = 1'b0;
`endif
    end
  end

endmodule
